// File: rtl/motion_pkg.sv
// Shared types and widths for the motion segment controller and the
// speed_integrator wiring around it.
package motion_pkg;

    localparam int MOTION_VW = 64;   // velocity / acceleration width (signed)
    localparam int MOTION_LW = 32;   // segment length counter width

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic signed [MOTION_VW-1:0] v0;
        logic signed [MOTION_VW-1:0] a;
        logic        [MOTION_LW-1:0] len;
        logic                        load_v0;
    } segment_t;

endpackage

// File: rtl/segment_slot.sv
// Single-entry prefetch register: valid/ready on the write side,
// pop and flush on the read side.
module segment_slot
    import motion_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     i_valid,
    output logic     o_ready,
    input  segment_t i_data,
    input  logic     i_pop,
    input  logic     i_flush,
    output logic     o_full,
    output segment_t o_data
);

    logic     r_full;
    segment_t r_data;

    // Occupancy flag: flush and pop empty the slot, a write into an empty slot fills it.
    always_ff @(posedge clk) begin
        // NOTE: registers are assigned with <= so every flop samples pre-edge values.
        if (reset) begin
            r_full <= 1'b0;
        end else if (i_flush || i_pop) begin
            r_full <= 1'b0;
        end else if (i_valid && !r_full) begin
            r_full <= 1'b1;
        end
    end

    // Payload capture on an accepted write; a flush in the same cycle drops it.
    always_ff @(posedge clk) begin
        // NOTE: the payload is deliberately not reset; r_full alone says whether it is meaningful.
        if (i_valid && !r_full && !i_flush) begin
            r_data <= i_data;
        end
    end

    assign o_ready = !r_full;
    assign o_full  = r_full;
    assign o_data  = r_data;

endmodule

// File: rtl/motion_segment_controller.sv
// Sequences velocity segments into one speed_integrator axis at a fixed
// update rate, chaining prefetched segments without a gap and forcing a
// stop when the queue runs dry while moving.
module motion_segment_controller
    import motion_pkg::*;
#(
    parameter int ACC_DIV = 4,
    parameter int VW      = MOTION_VW,
    parameter int LW      = MOTION_LW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          seg_valid,
    output logic          seg_ready,
    input  logic [VW-1:0] seg_v0,
    input  logic [VW-1:0] seg_a,
    input  logic [LW-1:0] seg_len,
    input  logic          seg_load_v0,
    input  logic          abort,
    output logic          set_v,
    output logic [VW-1:0] v_val,
    output logic          seg_done,
    output logic          busy,
    output logic          underrun
);

    localparam logic [31:0] DIV_RELOAD = 32'(ACC_DIV - 1);

    state_t        r_state;
    logic [VW-1:0] r_v_cur;
    logic [VW-1:0] r_a;
    logic [LW-1:0] r_remain;
    logic [31:0]   r_div;
    logic          r_set_v;
    logic          r_seg_done;
    logic          r_busy;
    logic          r_underrun;

    segment_t      w_seg_in;
    segment_t      w_slot_data;
    logic          w_slot_wr;
    logic          w_slot_ready;
    logic          w_slot_full;
    logic          w_update;
    logic          w_last;
    logic          w_pop;
    logic [VW-1:0] w_vn;

    // Zero-length segments never enter the slot, so they have no effect at all.
    assign w_seg_in  = '{v0: seg_v0, a: seg_a, len: seg_len, load_v0: seg_load_v0};
    assign w_slot_wr = seg_valid && (seg_len != '0);

    segment_slot u_slot (
        .clk     (clk),
        .reset   (reset),
        .i_valid (w_slot_wr),
        .o_ready (w_slot_ready),
        .i_data  (w_seg_in),
        .i_pop   (w_pop),
        .i_flush (abort),
        .o_full  (w_slot_full),
        .o_data  (w_slot_data)
    );

    // Update-tick decode and slot pop: the slot moves to active when idle or on the last update.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch can be inferred.
        w_update = 1'b0;
        w_last   = 1'b0;
        w_pop    = 1'b0;
        w_vn     = r_v_cur + r_a;
        if (r_state == RUN && r_div == '0) begin
            w_update = 1'b1;
            w_last   = (r_remain == LW'(1));
        end
        if (!abort && w_slot_full && (r_state == IDLE || w_last)) begin
            w_pop = 1'b1;
        end
    end

    // Main sequencer: abort first, then segment load in IDLE, then the divided update tick in RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_v_cur    <= '0;
            r_a        <= '0;
            r_remain   <= '0;
            r_div      <= '0;
            r_set_v    <= 1'b0;
            r_seg_done <= 1'b0;
            r_busy     <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_set_v    <= 1'b0;
            r_seg_done <= 1'b0;
            r_busy     <= (r_state == RUN) || w_slot_full;
            if (abort) begin
                r_state    <= IDLE;
                r_v_cur    <= '0;
                r_a        <= '0;
                r_remain   <= '0;
                r_div      <= '0;
                r_set_v    <= 1'b1;
                r_busy     <= 1'b0;
                r_underrun <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_slot_full) begin
                            r_state  <= RUN;
                            r_a      <= w_slot_data.a;
                            r_remain <= w_slot_data.len;
                            r_div    <= DIV_RELOAD;
                            if (w_slot_data.load_v0) begin
                                r_v_cur <= w_slot_data.v0;
                                r_set_v <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if (w_update) begin
                            r_set_v  <= 1'b1;
                            r_v_cur  <= w_vn;
                            r_remain <= r_remain - LW'(1);
                            r_div    <= DIV_RELOAD;
                            if (w_last) begin
                                r_seg_done <= 1'b1;
                                if (w_slot_full) begin
                                    r_a      <= w_slot_data.a;
                                    r_remain <= w_slot_data.len;
                                    if (w_slot_data.load_v0) begin
                                        r_v_cur <= w_slot_data.v0;
                                    end
                                end else if (w_vn == '0) begin
                                    r_state <= IDLE;
                                end else begin
                                    r_v_cur    <= '0;
                                    r_underrun <= 1'b1;
                                    r_state    <= IDLE;
                                end
                            end
                        end else begin
                            r_div <= r_div - 32'd1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign seg_ready = w_slot_ready;
    assign set_v     = r_set_v;
    assign v_val     = r_v_cur;
    assign seg_done  = r_seg_done;
    assign busy      = r_busy;
    assign underrun  = r_underrun;

endmodule

// File: tb/tb_motion_segment_controller.sv
// Self-checking bench for motion_segment_controller (ACC_DIV = 4).
// Expected integrator events are queued when a segment is driven and
// compared by a monitor whenever set_v or seg_done fires.
module tb_motion_segment_controller;

    localparam logic [63:0] VMAX = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] VMIN = 64'h8000_0000_0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        seg_valid;
    logic        seg_ready;
    logic [63:0] seg_v0;
    logic [63:0] seg_a;
    logic [31:0] seg_len;
    logic        seg_load_v0;
    logic        abort;
    logic        set_v;
    logic [63:0] v_val;
    logic        seg_done;
    logic        busy;
    logic        underrun;

    motion_segment_controller #(.ACC_DIV(4), .VW(64), .LW(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .seg_valid   (seg_valid),
        .seg_ready   (seg_ready),
        .seg_v0      (seg_v0),
        .seg_a       (seg_a),
        .seg_len     (seg_len),
        .seg_load_v0 (seg_load_v0),
        .abort       (abort),
        .set_v       (set_v),
        .v_val       (v_val),
        .seg_done    (seg_done),
        .busy        (busy),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    // Expected integrator event: cycle relative to the scenario start, velocity, done flag.
    typedef struct {
        int          cyc;
        logic [63:0] v;
        logic        done;
    } ev_t;

    typedef struct packed {
        logic [63:0]      v0;
        logic [63:0]      a;
        logic [31:0]      len;
        logic             load;
        logic [7:0]       n_ev;
        logic [2:0][7:0]  ev_cyc;
        logic [2:0][63:0] ev_v;
        logic [2:0]       ev_done;
        logic             exp_busy2;
        logic             exp_underrun;
    } vec_t;

    ev_t  exp_q[$];
    vec_t vt[6];
    int   cyc = 0;
    int   base = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    logic mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc - base);
        end
    endtask

    // Scoreboard monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (mon_en && (set_v === 1'b1 || seg_done === 1'b1)) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL spurious_event: set_v=%b seg_done=%b v_val=0x%0h at cycle %0d, none expected",
                         set_v, seg_done, v_val, cyc - base);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                check("ev_cycle", 64'(cyc - base), 64'(e.cyc));
                check("ev_set_v", {63'd0, set_v}, 64'd1);
                check("ev_v_val", v_val, e.v);
                check("ev_seg_done", {63'd0, seg_done}, {63'd0, e.done});
            end
        end
    end

    task automatic push_ev(input int c, input logic [63:0] v, input logic d);
        ev_t e;
        e.cyc  = c;
        e.v    = v;
        e.done = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_to(input int c);
        while ((cyc - base) < c) @(negedge clk);
    endtask

    // Holds reset for n cycles, leaves the bench at a negedge with reset low and a fresh cycle base.
    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b1;
        repeat (n) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        base = cyc;
    endtask

    // Offers one segment for exactly one cycle starting at the current negedge.
    task automatic offer(input logic [63:0] v0, input logic [63:0] a, input logic [31:0] len, input logic ld);
        seg_v0      = v0;
        seg_a       = a;
        seg_len     = len;
        seg_load_v0 = ld;
        seg_valid   = 1'b1;
        @(negedge clk);
        seg_valid   = 1'b0;
    endtask

    function automatic vec_t mk(input logic [63:0] v0, input logic [63:0] a, input logic [31:0] len,
                                input logic ld, input int n,
                                input int c0, input logic [63:0] e0, input logic d0,
                                input int c1, input logic [63:0] e1, input logic d1,
                                input int c2, input logic [63:0] e2, input logic d2,
                                input logic b2, input logic und);
        vec_t r;
        r.v0 = v0; r.a = a; r.len = len; r.load = ld; r.n_ev = 8'(n);
        r.ev_cyc[0] = 8'(c0); r.ev_v[0] = e0; r.ev_done[0] = d0;
        r.ev_cyc[1] = 8'(c1); r.ev_v[1] = e1; r.ev_done[1] = d1;
        r.ev_cyc[2] = 8'(c2); r.ev_v[2] = e2; r.ev_done[2] = d2;
        r.exp_busy2 = b2; r.exp_underrun = und;
        return r;
    endfunction

    initial begin
        reset = 1'b1; seg_valid = 1'b0; abort = 1'b0;
        seg_v0 = '0; seg_a = '0; seg_len = '0; seg_load_v0 = 1'b0;

        // Single-segment vectors: inputs, expected strobes, busy at cycle 2, final underrun.
        vt[0] = mk(64'd100, 64'(-50), 32'd2, 1'b1, 3, 2, 64'd100, 0, 6, 64'd50, 0, 10, 64'd0, 1, 1'b1, 1'b0);
        vt[1] = mk(64'd0, 64'd5, 32'd2, 1'b1, 3, 2, 64'd0, 0, 6, 64'd5, 0, 10, 64'd0, 1, 1'b1, 1'b1);
        vt[2] = mk(VMAX, 64'd1, 32'd2, 1'b1, 3, 2, VMAX, 0, 6, VMIN, 0, 10, 64'd0, 1, 1'b1, 1'b1);
        vt[3] = mk(64'd77, 64'd3, 32'd0, 1'b1, 0, 0, 64'd0, 0, 0, 64'd0, 0, 0, 64'd0, 0, 1'b0, 1'b0);
        vt[4] = mk(64'd999, 64'd7, 32'd1, 1'b0, 1, 6, 64'd0, 1, 0, 64'd0, 0, 0, 64'd0, 0, 1'b1, 1'b1);
        vt[5] = mk(64'd0, 64'd0, 32'd1, 1'b1, 2, 2, 64'd0, 0, 6, 64'd0, 1, 0, 64'd0, 0, 1'b1, 1'b0);

        // Reset held 3 cycles: outputs idle, then no strobe after release.
        repeat (3) @(negedge clk);
        check("rst_set_v", {63'd0, set_v}, 64'd0);
        check("rst_v_val", v_val, 64'd0);
        check("rst_seg_done", {63'd0, seg_done}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_underrun", {63'd0, underrun}, 64'd0);
        check("rst_seg_ready", {63'd0, seg_ready}, 64'd1);
        reset = 1'b0;
        base = cyc;
        mon_en = 1'b1;
        wait_to(6);

        // Table-driven single segments.
        for (int i = 0; i < 6; i++) begin
            do_reset(1);
            for (int k = 0; k < int'(vt[i].n_ev); k++)
                push_ev(int'(vt[i].ev_cyc[k]), vt[i].ev_v[k], vt[i].ev_done[k]);
            offer(vt[i].v0, vt[i].a, vt[i].len, vt[i].load);
            wait_to(2);
            check($sformatf("vec%0d_busy_c2", i), {63'd0, busy}, {63'd0, vt[i].exp_busy2});
            wait_to(14);
            check($sformatf("vec%0d_all_events", i), 64'(exp_q.size()), 64'd0);
            check($sformatf("vec%0d_underrun", i), {63'd0, underrun}, {63'd0, vt[i].exp_underrun});
            check($sformatf("vec%0d_busy_end", i), {63'd0, busy}, 64'd0);
            check($sformatf("vec%0d_ready_end", i), {63'd0, seg_ready}, 64'd1);
        end

        // busy timing around the clean stop at cycle 10.
        do_reset(1);
        push_ev(2, 64'd100, 0); push_ev(6, 64'd50, 0); push_ev(10, 64'd0, 1);
        offer(64'd100, 64'(-50), 32'd2, 1'b1);
        wait_to(9);  check("busy_c9", {63'd0, busy}, 64'd1);
        wait_to(10); check("busy_c10", {63'd0, busy}, 64'd1);
        wait_to(11); check("busy_c11", {63'd0, busy}, 64'd0);

        // Back-to-back: B continues from A's velocity, then the dry queue forces a stop.
        do_reset(1);
        push_ev(2, 64'd0, 0); push_ev(6, 64'd10, 0); push_ev(10, 64'd20, 1);
        push_ev(14, 64'd20, 0); push_ev(18, 64'd0, 1);
        offer(64'd0, 64'd10, 32'd2, 1'b1);
        wait_to(3);
        check("b2b_ready_c3", {63'd0, seg_ready}, 64'd1);
        offer(64'd555, 64'd0, 32'd2, 1'b0);
        wait_to(5);  check("b2b_ready_c5", {63'd0, seg_ready}, 64'd0);
        wait_to(9);  check("b2b_ready_c9", {63'd0, seg_ready}, 64'd0);
        wait_to(11); check("b2b_ready_c11", {63'd0, seg_ready}, 64'd1);
        wait_to(17); check("b2b_underrun_c17", {63'd0, underrun}, 64'd0);
        wait_to(19); check("b2b_underrun_c19", {63'd0, underrun}, 64'd1);
        wait_to(22); check("b2b_underrun_sticky", {63'd0, underrun}, 64'd1);
        push_ev(23, 64'd0, 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_to(24);
        check("b2b_underrun_cleared", {63'd0, underrun}, 64'd0);
        check("b2b_all_events", 64'(exp_q.size()), 64'd0);

        // Chained segment with load_v0 replaces the computed velocity.
        do_reset(1);
        push_ev(2, 64'd40, 0); push_ev(6, 64'(-30), 1); push_ev(10, 64'd0, 1);
        offer(64'd40, 64'd0, 32'd1, 1'b1);
        wait_to(3);
        offer(64'(-30), 64'd30, 32'd1, 1'b1);
        wait_to(12);
        check("reload_underrun", {63'd0, underrun}, 64'd0);
        check("reload_all_events", 64'(exp_q.size()), 64'd0);

        // Abort at cycle 7 with a segment waiting in the slot.
        do_reset(1);
        push_ev(2, 64'd100, 0); push_ev(6, 64'd50, 0); push_ev(8, 64'd0, 0);
        offer(64'd100, 64'(-50), 32'd2, 1'b1);
        wait_to(3);
        offer(64'd7, 64'd7, 32'd3, 1'b1);
        wait_to(7);
        check("abort_slot_full_c7", {63'd0, seg_ready}, 64'd0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_ready_c8", {63'd0, seg_ready}, 64'd1);
        check("abort_busy_c8", {63'd0, busy}, 64'd0);
        wait_to(20);
        check("abort_all_events", 64'(exp_q.size()), 64'd0);

        // Handshake coinciding with abort is dropped.
        do_reset(1);
        push_ev(1, 64'd0, 0);
        abort = 1'b1;
        offer(64'd9, 64'd1, 32'd2, 1'b1);
        abort = 1'b0;
        wait_to(3);
        check("abort_hs_ready", {63'd0, seg_ready}, 64'd1);
        wait_to(12);
        check("abort_hs_busy", {63'd0, busy}, 64'd0);
        check("abort_hs_all_events", 64'(exp_q.size()), 64'd0);

        // Reset mid-run: outputs return to reset values, no strobe afterwards.
        do_reset(1);
        push_ev(2, 64'd100, 0);
        offer(64'd100, 64'(-50), 32'd2, 1'b1);
        wait_to(4);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_set_v", {63'd0, set_v}, 64'd0);
        check("midrst_v_val", v_val, 64'd0);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_ready", {63'd0, seg_ready}, 64'd1);
        reset = 1'b0;
        wait_to(16);
        check("midrst_all_events", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
